// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// NREQ writeback requesters. The granted write is registered for one cycle
// before it reaches the register file, which samples it on the next negedge.
// Optional feature macro: REGFILE_CLEAR_EN -- when defined, a post-reset CLEAR
// sequence writes zero to x1..x31 before any requester is accepted.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               reg_wrW,
    output logic [AW-1:0]      waddr,
    output logic [DW-1:0]      wdata,
    output logic               init_done
);

    // Pointer width, plus one spare bit so ptr + offset cannot overflow before wrapping
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = PW + 1;

`ifdef REGFILE_CLEAR_EN
    typedef enum logic {
        StClear = 1'b0,
        StRun   = 1'b1
    } state_e;

    localparam state_e ResetState = StClear;
    // Highest register index visited by the clear walk (x31 for AW=5)
    localparam logic [AW-1:0] LastReg = '1;
`else
    typedef enum logic {
        StRun = 1'b1
    } state_e;

    localparam state_e ResetState = StRun;
`endif

    state_e          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            init_done_q, init_done_d;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            grant_found;
    logic [SW-1:0]   cand;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            in_clear;

`ifdef REGFILE_CLEAR_EN
    logic [AW-1:0]   cnt_q, cnt_d;

    assign in_clear = (state_q == StClear);
`else
    assign in_clear = 1'b0;
`endif

    // Round-robin search from rr_ptr; only live once init_done is up
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        if (state_q == StRun && init_done_q) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = {1'b0, rr_ptr_q} + SW'(k);
                if (cand >= SW'(NREQ)) begin
                    cand = cand - SW'(NREQ);
                end
                if (!grant_found && req_valid[cand[PW-1:0]]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand[PW-1:0];
                end
            end
            grant[grant_idx] = grant_found;
        end
    end

    // Select address/data of the granted requester
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Advance the pointer past the winner on every transfer, including x0 drops
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_found) begin
            if (grant_idx == PW'(NREQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + PW'(1);
            end
        end
    end

    // Next state and registered write-port values
    always_comb begin
        state_d = state_q;
        wr_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef REGFILE_CLEAR_EN
        cnt_d   = cnt_q;
`endif
        if (in_clear) begin
`ifdef REGFILE_CLEAR_EN
            wr_d    = 1'b1;
            waddr_d = cnt_q;
            wdata_d = '0;
            cnt_d   = cnt_q + AW'(1);
            if (cnt_q == LastReg) begin
                state_d = StRun;
            end
`endif
        end else if (grant_found && (sel_addr != '0)) begin
            // Writes to x0 are accepted upstream but never reach the register file
            wr_d    = 1'b1;
            waddr_d = sel_addr;
            wdata_d = sel_data;
        end
    end

    // init_done trails entry into RUN by one cycle
    assign init_done_d = (state_q == StRun);

    // State, pointer and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ResetState;
            rr_ptr_q    <= '0;
            wr_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_q        <= wr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            init_done_q <= init_done_d;
        end
    end

`ifdef REGFILE_CLEAR_EN
    // Clear-walk counter, restarting at x1 after every reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= AW'(1);
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign req_ready = grant;
    assign reg_wrW   = wr_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign init_done = init_done_q;

endmodule
